// File: rtl/soc_pkg.sv
// Shared types and constants for the SoC memory path.
// Used by the I/D memory arbiter and its round-robin picker.
package soc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    localparam int MEM_LAT_MAX = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker: a lone request wins outright.
// On contention, the requester that did not win last time is granted.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port, fixed-latency memory between instruction fetch (I)
// and load/store (D). Only one access is outstanding at any time.
module mem_arbiter
    import soc_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int LAT_W = $clog2(MEM_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_END = LAT_W'(MEM_LAT);

    if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX || (DATA_W % 8) != 0) begin : g_bad_param
        $error("mem_arbiter: illegal MEM_LAT or DATA_W");
    end

    state_t           state;
    logic [LAT_W-1:0] lat_cnt;
    logic             owner;
    logic             last_gnt;

    logic       done;
    logic       window;
    logic [1:0] pick;
    logic [1:0] gnt;

    // The completion cycle doubles as a grant slot, giving one access per MEM_LAT cycles.
    assign done   = (state == ST_BUSY) && (lat_cnt == LAT_END);
    assign window = !rst && ((state == ST_IDLE) || done);

    arb_rr2 u_arb (
        .req  ({d_req, i_req}),
        .last (last_gnt),
        .gnt  (pick)
    );

    assign gnt   = window ? pick : 2'b00;
    assign i_gnt = gnt[0];
    assign d_gnt = gnt[1];

    assign mem_en    = |gnt;
    assign mem_addr  = gnt[1] ? d_addr : i_addr;
    assign mem_we    = (gnt[1] && d_we) ? d_be : '0;
    assign mem_wdata = d_wdata;

    assign i_rvalid = !rst && done && (owner == REQ_I);
    assign d_rvalid = !rst && done && (owner == REQ_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lat_cnt  <= '0;
            owner    <= REQ_I;
            last_gnt <= REQ_I;
        end else if (|gnt) begin
            state    <= ST_BUSY;
            lat_cnt  <= LAT_W'(1);
            owner    <= gnt[1];
            last_gnt <= gnt[1];
        end else if (done) begin
            state   <= ST_IDLE;
            lat_cnt <= '0;
        end else if (state == ST_BUSY) begin
            lat_cnt <= lat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: three instances with MEM_LAT = 1, 2, 3,
// a latency-accurate memory model and a grant-to-rvalid scoreboard.
module tb_mem_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req    [N];
    logic [31:0] i_addr   [N];
    logic        i_gnt    [N];
    logic        i_rvalid [N];
    logic [31:0] i_rdata  [N];
    logic        d_req    [N];
    logic        d_we     [N];
    logic [3:0]  d_be     [N];
    logic [31:0] d_addr   [N];
    logic [31:0] d_wdata  [N];
    logic        d_gnt    [N];
    logic        d_rvalid [N];
    logic [31:0] d_rdata  [N];
    logic        mem_en   [N];
    logic [3:0]  mem_we   [N];
    logic [31:0] mem_addr [N];
    logic [31:0] mem_wdata[N];
    logic [31:0] mem_rdata[N];
    logic [31:0] pipe     [N][N];

    typedef struct {
        int          g;
        logic        who;
        logic        is_wr;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   now     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .i_req     (i_req[g]),
            .i_addr    (i_addr[g]),
            .i_gnt     (i_gnt[g]),
            .i_rvalid  (i_rvalid[g]),
            .i_rdata   (i_rdata[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_be      (d_be[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_gnt     (d_gnt[g]),
            .d_rvalid  (d_rvalid[g]),
            .d_rdata   (d_rdata[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g])
        );
        assign mem_rdata[g] = pipe[g][g];
    end

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : {16'hA5A5, a[15:0]};
    endfunction

    // Memory: data for an access appears MEM_LAT edges after its mem_en.
    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            for (int s = N - 1; s > 0; s--) pipe[g][s] <= pipe[g][s-1];
            pipe[g][0] <= mem_en[g] ? rd_fn(mem_addr[g]) : 32'h0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
        now++;
    endtask

    // Sample mid-cycle and run the scoreboard for every instance.
    task automatic smp();
        exp_t e;
        int   idx;
        @(negedge clk);
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                chk($sformatf("rst_out%0d", g),
                    {i_gnt[g], d_gnt[g], i_rvalid[g], d_rvalid[g], mem_en[g], mem_we[g]}, 64'd0);
                continue;
            end
            chk($sformatf("gnt_excl%0d", g), i_gnt[g] & d_gnt[g], 64'd0);
            if (i_gnt[g]) begin
                chk($sformatf("i_mem%0d", g), {mem_en[g], mem_we[g], mem_addr[g]}, {1'b1, 4'h0, i_addr[g]});
                e = '{g: g, who: 1'b0, is_wr: 1'b0, data: rd_fn(i_addr[g]), due: now + g + 1};
                sb.push_back(e);
            end else if (d_gnt[g]) begin
                chk($sformatf("d_mem%0d", g), {mem_en[g], mem_we[g], mem_addr[g]},
                    {1'b1, (d_we[g] ? d_be[g] : 4'h0), d_addr[g]});
                if (d_we[g]) chk($sformatf("d_wdata%0d", g), mem_wdata[g], d_wdata[g]);
                e = '{g: g, who: 1'b1, is_wr: d_we[g], data: rd_fn(d_addr[g]), due: now + g + 1};
                sb.push_back(e);
            end else begin
                chk($sformatf("idle_mem%0d", g), {mem_en[g], mem_we[g]}, 64'd0);
            end
            idx = -1;
            foreach (sb[k]) if (idx < 0 && sb[k].g == g) idx = k;
            if (i_rvalid[g] || d_rvalid[g]) begin
                if (idx < 0) begin
                    chk($sformatf("rv_spurious%0d", g), 64'd1, 64'd0);
                end else begin
                    e = sb[idx];
                    sb.delete(idx);
                    chk($sformatf("rv_who%0d", g), {i_rvalid[g], d_rvalid[g]}, {~e.who, e.who});
                    chk($sformatf("rv_cyc%0d", g), now, e.due);
                    if (!e.who) chk($sformatf("i_rdata%0d", g), i_rdata[g], e.data);
                    else if (!e.is_wr) chk($sformatf("d_rdata%0d", g), d_rdata[g], e.data);
                end
            end else if (idx >= 0 && sb[idx].due <= now) begin
                chk($sformatf("rv_missing%0d", g), 64'd0, 64'd1);
                sb.delete(idx);
            end
        end
        if (rst) sb.delete();
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            i_req[g] = 0; i_addr[g] = '0; d_req[g] = 0; d_we[g] = 0;
            d_be[g] = '0; d_addr[g] = '0; d_wdata[g] = '0;
        end
        // Reset with both requests high, then strict D/I alternation.
        rst = 1; i_req[0] = 1; d_req[0] = 1; i_addr[0] = 32'h40; d_addr[0] = 32'h80;
        repeat (3) begin smp(); adv(); end
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            smp();
            chk($sformatf("rr_d%0d", k), d_gnt[0], (k % 2 == 0));
            chk($sformatf("rr_i%0d", k), i_gnt[0], (k % 2 == 1));
            adv();
        end
        i_req[0] = 0; d_req[0] = 0;
        smp(); adv();

        // Single fetch, MEM_LAT=1.
        i_req[0] = 1; i_addr[0] = 32'h100;
        smp();
        chk("t2_gnt", {i_gnt[0], mem_en[0], mem_we[0], mem_addr[0]}, {1'b1, 1'b1, 4'h0, 32'h100});
        adv();
        i_req[0] = 0;
        smp();
        chk("t2_rv", {i_rvalid[0], i_rdata[0]}, {1'b1, 32'h13});
        adv();

        // Write with a pending fetch, MEM_LAT=3.
        d_req[2] = 1; d_we[2] = 1; d_be[2] = 4'b0011; d_addr[2] = 32'h200; d_wdata[2] = 32'hDEADBEEF;
        i_req[2] = 1; i_addr[2] = 32'h204;
        smp();
        chk("t4_gnt", {d_gnt[2], i_gnt[2], mem_we[2]}, {1'b1, 1'b0, 4'b0011});
        chk("t4_wdata", mem_wdata[2], 32'hDEADBEEF);
        adv();
        d_req[2] = 0; d_we[2] = 0;
        for (int k = 1; k <= 2; k++) begin
            smp(); chk($sformatf("t4_nogt%0d", k), {i_gnt[2], d_gnt[2]}, 64'd0); adv();
        end
        smp();
        chk("t4_c3", {d_rvalid[2], i_gnt[2], mem_addr[2]}, {1'b1, 1'b1, 32'h204});
        adv();
        i_req[2] = 0;
        for (int k = 4; k <= 5; k++) begin
            smp(); chk($sformatf("t4_norv%0d", k), i_rvalid[2], 64'd0); adv();
        end
        smp();
        chk("t4_c6", {i_rvalid[2], i_rdata[2]}, {1'b1, rd_fn(32'h204)});
        adv();

        // Reset in the middle of an access, MEM_LAT=3.
        i_req[2] = 1; i_addr[2] = 32'h300;
        smp(); chk("t5_gnt0", i_gnt[2], 64'd1); adv();
        i_req[2] = 0; rst = 1;
        smp(); chk("t5_rst", i_rvalid[2], 64'd0); adv();
        rst = 0; i_req[2] = 1; i_addr[2] = 32'h304;
        smp(); chk("t5_gnt2", i_gnt[2], 64'd1); adv();
        i_req[2] = 0;
        for (int k = 3; k <= 4; k++) begin
            smp(); chk($sformatf("t5_norv%0d", k), i_rvalid[2], 64'd0); adv();
        end
        smp();
        chk("t5_rv5", {i_rvalid[2], i_rdata[2]}, {1'b1, rd_fn(32'h304)});
        adv();

        // D request withdrawn while I is busy, MEM_LAT=2.
        i_req[1] = 1; i_addr[1] = 32'h400;
        smp(); chk("t6_igt", i_gnt[1], 64'd1); adv();
        i_req[1] = 0; d_req[1] = 1; d_we[1] = 1; d_be[1] = 4'hF; d_addr[1] = 32'h500; d_wdata[1] = 32'h1234_5678;
        smp(); chk("t6_busy", {d_gnt[1], mem_en[1], mem_we[1]}, 64'd0); adv();
        d_req[1] = 0; d_we[1] = 0;
        smp(); chk("t6_done", {i_rvalid[1], d_gnt[1], mem_en[1]}, {1'b1, 1'b0, 1'b0}); adv();
        smp(); chk("t6_nodrv", d_rvalid[1], 64'd0); adv();

        repeat (2) begin smp(); adv(); end
        chk("sb_empty", sb.size(), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
